// File: rtl/deser_pkg.sv
// Shared encodings and defaults for the serial deserializer.
// DESER_PARITY_EN enables the trailing even-parity bit.
package deser_pkg;

  localparam int DESER_WIDTH = 8;

  localparam logic [1:0] DESER_IDLE   = 2'd0;
  localparam logic [1:0] DESER_SHIFT  = 2'd1;
  localparam logic [1:0] DESER_PARITY = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = DESER_IDLE,
    S_SHIFT  = DESER_SHIFT,
    S_PARITY = DESER_PARITY
  } deser_state_e;

endpackage

// File: rtl/serial_deserializer_if.sv
// Serial-in / word-out bundle of the deserializer.
// Port set is the same with or without DESER_PARITY_EN.
interface serial_deserializer_if
  import deser_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH
);

  logic             start;
  logic             sin;
  logic             sin_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic             parity_err;

  modport master (
    output start, sin, sin_valid, out_ready,
    input  out_data, out_valid, overrun, parity_err
  );

  modport slave (
    input  start, sin, sin_valid, out_ready,
    output out_data, out_valid, overrun, parity_err
  );

endinterface

// File: rtl/deser_bit_counter.sv
// Received-bit counter for one deserializer frame.
// Shared by both DESER_PARITY_EN builds.
module deser_bit_counter
  import deser_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH
) (
  input  logic                         clock,
  input  logic                         clear,
  input  logic                         load1,
  input  logic                         inc,
  output logic [$clog2(WIDTH+1)-1:0]   count,
  output logic                         done
);

  localparam int CW = $clog2(WIDTH+1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count_q <= '0;
    end else if (load1) begin
      count_q <= CW'(1);
    end else if (inc) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;
  assign done  = (count_q == CW'(WIDTH));

endmodule

// File: rtl/serial_deserializer.sv
// LSB-first serial-to-parallel receiver with double-buffered output.
// Define DESER_PARITY_EN to add a trailing even-parity bit per frame.
module serial_deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH
) (
  input  logic                  clock,
  input  logic                  clear,
  serial_deserializer_if.slave  bus
);

  localparam int CW = $clog2(WIDTH+1);

  deser_state_e     state_q;
  deser_state_e     last_nxt;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] word_d;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic             overrun_q;
  logic             perr_q;
  logic             perr_d;
  logic             take;
  logic             fresh;
  logic             shifting;
  logic             last;
  logic             par_done;
  logic             commit;
  logic             inc;
  logic [CW-1:0]    count;
  logic             done;

  always_comb begin
    take     = bus.sin_valid;
    fresh    = take && bus.start;
    shifting = take && !fresh && (state_q == S_SHIFT);
    sr_d     = {bus.sin, sr_q[WIDTH-1:1]};
    last     = shifting && (count == CW'(WIDTH-1));
    inc      = shifting && !done;
`ifdef DESER_PARITY_EN
    last_nxt = S_PARITY;
    par_done = take && !fresh && (state_q == S_PARITY);
    commit   = par_done;
    word_d   = sr_q;
    perr_d   = ^{sr_q, bus.sin};
`else
    last_nxt = S_IDLE;
    par_done = 1'b0;
    commit   = last;
    word_d   = sr_d;
    perr_d   = 1'b0;
`endif
  end

  deser_bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clock (clock),
    .clear (clear),
    .load1 (fresh),
    .inc   (inc),
    .count (count),
    .done  (done)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q     <= S_IDLE;
      sr_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      if (fresh || shifting) begin
        sr_q <= sr_d;
      end
      unique case (1'b1)
        fresh:    state_q <= S_SHIFT;
        last:     state_q <= last_nxt;
        par_done: state_q <= S_IDLE;
        default:  ;
      endcase
      // a full buffer that is not being drained loses the new word
      if (commit) begin
        if (!out_valid_q || bus.out_ready) begin
          out_data_q  <= word_d;
          perr_q      <= perr_d;
          out_valid_q <= 1'b1;
        end else begin
          overrun_q   <= 1'b1;
        end
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.parity_err = perr_q;

endmodule
